// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state type
// and the default operand width.
package seq_div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/addsub_n.sv
// N-bit adder/subtractor; sub=1 gives a-b, sub=0 gives a+b (modulo 2^N).
module addsub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_div4.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIV4_DBZ_EN: zero divisor bypasses the iterations and flags div_by_zero.
module seq_div4
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state, state_nxt;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic [CNT_W-1:0] cnt_m1;
  logic             last_step;
  logic             zero_div;

  // One restoring step: shift {A,Q} left, trial-subtract M, keep or restore.
  assign a_sh = (WIDTH+1)'({a_r, q_r[WIDTH-1]});
  assign q_sh = WIDTH'({q_r, 1'b0});

  addsub_n #(.N(WIDTH + 1)) u_trial (
    .a   (a_sh),
    .b   ({1'b0, m_r}),
    .sub (1'b1),
    .y   (trial)
  );

  addsub_n #(.N(CNT_W)) u_cnt_dec (
    .a   (cnt_r),
    .b   (CNT_W'(1)),
    .sub (1'b1),
    .y   (cnt_m1)
  );

  assign a_step    = trial[WIDTH] ? a_sh : trial;
  assign q_step    = {q_sh[WIDTH-1:1], ~trial[WIDTH]};
  assign last_step = (cnt_r == CNT_W'(1));

`ifdef SEQ_DIV4_DBZ_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = zero_div ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers and held results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_r   <= '0;
      q_r   <= '0;
      m_r   <= '0;
      cnt_r <= '0;
      quo_r <= '0;
      rem_r <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= '0;
          q_r   <= dividend;
          m_r   <= divisor;
          cnt_r <= CNT_W'(WIDTH);
          if (zero_div) begin
            quo_r <= '1;
            rem_r <= dividend;
          end
        end
        RUN: begin
          a_r   <= a_step;
          q_r   <= q_step;
          cnt_r <= cnt_m1;
          if (last_step) begin
            quo_r <= q_step;
            rem_r <= a_step[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_DIV4_DBZ_EN
  logic dbz_r;

  // Flag lives only for the DONE cycle of a bypassed division.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                        dbz_r <= 1'b0;
    else if (state == IDLE && start)    dbz_r <= zero_div;
    else if (state == DONE)             dbz_r <= 1'b0;
  end

  assign div_by_zero = dbz_r;
`else
  assign div_by_zero = 1'b0;
`endif

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: tb/tb_seq_div4.sv
// Randomized self-checking bench for seq_div4 against an arithmetic reference model.
module tb_seq_div4;

  localparam int W = 4;
`ifdef SEQ_DIV4_DBZ_EN
  localparam bit DBZ_BUILD = 1'b1;
`else
  localparam bit DBZ_BUILD = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_div4 #(.WIDTH(W)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, zero divisor gives all-ones and the dividend back.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int lat, output int dbz);
    if (b == 0) begin
      q   = (1 << W) - 1;
      r   = a;
      lat = DBZ_BUILD ? 1 : W + 1;
      dbz = DBZ_BUILD ? 1 : 0;
    end else begin
      q   = a / b;
      r   = a % b;
      lat = W + 1;
      dbz = 0;
    end
  endfunction

  // Entered and left #1 after a rising edge with the DUT in IDLE.
  task automatic do_div(input int a, input int b, input bit ign, input bit scramble);
    int q_exp, r_exp, lat, dbz, edges, busy_cnt;
    int q_hold, r_hold;
    bit seen;
    model(a, b, q_exp, r_exp, lat, dbz);
    q_hold   = quotient;
    r_hold   = remainder;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    edges    = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clock);
      #1;
      edges++;
      start = (ign && edges == 2);
      if (ign && edges == 2) begin
        dividend = 4'd6;
        divisor  = 4'd2;
      end else if (scramble) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        check("hold_quotient", quotient, q_hold);
        check("hold_remainder", remainder, r_hold);
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("latency", edges, lat);
    check("busy_cycles", busy_cnt, lat - 1);
    check("quotient", quotient, q_exp);
    check("remainder", remainder, r_exp);
    check("div_by_zero", div_by_zero, dbz);
    @(posedge clock);
    #1;
    check("done_one_cycle", done, 0);
    check("dbz_cleared", div_by_zero, 0);
    if (ign) begin
      repeat (8) begin
        @(posedge clock);
        #1;
        check("no_queued_done", done, 0);
      end
    end
  endtask

  initial begin
    int q_exp, r_exp, lat, dbz, edges;
    bit seen;

    resetn   = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;

    do_div(13, 3, 1'b0, 1'b0);
    do_div(15, 1, 1'b0, 1'b0);
    do_div(7, 9, 1'b0, 1'b0);
    do_div(0, 5, 1'b0, 1'b0);
    do_div(9, 0, 1'b0, 1'b0);
    do_div(13, 3, 1'b1, 1'b0);

    // Abort in the third RUN cycle.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    repeat (3) begin
      @(posedge clock);
      #1;
      check("abort_no_done", done, 0);
    end
    resetn = 1'b1;
    do_div(10, 4, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_div(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'b0, 1'b1);
    end

    // Back-to-back sweep with start held high.
    dividend = 4'd0;
    divisor  = 4'd0;
    start    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      model(i >> 4, i & 15, q_exp, r_exp, lat, dbz);
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 20) begin
        @(posedge clock);
        #1;
        edges++;
        if (done) seen = 1'b1;
      end
      check("sweep_done_seen", seen, 1);
      check("sweep_gap", edges, lat + (i > 0 ? 1 : 0));
      check("sweep_quotient", quotient, q_exp);
      check("sweep_remainder", remainder, r_exp);
      check("sweep_dbz", div_by_zero, dbz);
      if (i < 255) begin
        dividend = W'((i + 1) >> 4);
        divisor  = W'((i + 1) & 15);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    check("sweep_end_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
